// File: rtl/reg_vram_sequencer_pkg.sv
// reg_vram_sequencer_pkg: register numbers, sequencer states and word type shared by the VRAM sequencer
package xv;
  localparam logic [3:0] XR_WR_INCR = 4'd0;
  localparam logic [3:0] XR_WR_ADDR = 4'd1;
  localparam logic [3:0] XR_DATA    = 4'd2;
  localparam logic [3:0] XR_RD_INCR = 4'd3;
  localparam logic [3:0] XR_RD_ADDR = 4'd4;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_WR, SEQ_RD} seq_state_t;
  typedef logic [15:0] word_t;
endpackage

// File: rtl/reg_vram_sequencer.sv
// reg_vram_sequencer: assembles register byte writes and sequences VRAM read/write requests to the arbiter
// XV_RD_PREFETCH_EN: an odd-byte read of DATA queues the next streaming read
module reg_vram_sequencer
  import xv::*;
#(
  parameter int VRAM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic                   write_strobe_i,
  input  logic                   read_strobe_i,
  input  logic [3:0]             reg_num_i,
  input  logic                   bytesel_i,
  input  logic [7:0]             bytedata_i,
  output logic                   vram_req_o,
  output logic                   vram_wr_o,
  output logic [VRAM_ADDR_W-1:0] vram_addr_o,
  output logic [15:0]            vram_data_o,
  input  logic                   vram_ack_i,
  input  logic [15:0]            vram_data_i,
  output logic [15:0]            rd_data_o,
  output logic                   busy_o,
  output logic                   overflow_o
);
  logic [7:0] hi;
  word_t wr_incr, rd_incr, wr_data, cval, wr_incr_n, rd_incr_n;
  logic [VRAM_ADDR_W-1:0] wr_addr, rd_addr, wr_addr_n, rd_addr_n;
  logic wr_pending, rd_pending, commit, c_wri, c_wra, c_data, c_rdi, c_rda, pf;
  logic wr_ack, rd_ack, wr_free, rd_free;
  seq_state_t state, state_n;
  assign commit = write_strobe_i & bytesel_i;
  assign cval   = {hi, bytedata_i};
  assign c_wri  = commit & (reg_num_i == XR_WR_INCR);
  assign c_wra  = commit & (reg_num_i == XR_WR_ADDR);
  assign c_data = commit & (reg_num_i == XR_DATA);
  assign c_rdi  = commit & (reg_num_i == XR_RD_INCR);
  assign c_rda  = commit & (reg_num_i == XR_RD_ADDR);
`ifdef XV_RD_PREFETCH_EN
  assign pf = read_strobe_i & bytesel_i & (reg_num_i == XR_DATA);
`else
  assign pf = read_strobe_i & 1'b0;
`endif
  assign wr_ack  = (state == SEQ_WR) & vram_ack_i;
  assign rd_ack  = (state == SEQ_RD) & vram_ack_i;
  // pending flags stay set until ack, so they also cover the in-flight access
  assign wr_free = ~wr_pending | wr_ack;
  assign rd_free = ~rd_pending | rd_ack;
  // ack-time increment applies to a value committed in the same cycle
  assign wr_addr_n = c_wra ? VRAM_ADDR_W'(cval) : wr_addr;
  assign rd_addr_n = c_rda ? VRAM_ADDR_W'(cval) : rd_addr;
  assign wr_incr_n = c_wri ? cval : wr_incr;
  assign rd_incr_n = c_rdi ? cval : rd_incr;
  assign busy_o    = wr_pending | rd_pending | (state != SEQ_IDLE);
  always_comb begin
    state_n = state;
    if (state == SEQ_IDLE)
      state_n = wr_pending ? SEQ_WR : rd_pending ? SEQ_RD : SEQ_IDLE;
    else if (vram_ack_i)
      state_n = SEQ_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= SEQ_IDLE;
      hi          <= '0;
      wr_incr     <= '0;
      rd_incr     <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_data     <= '0;
      wr_pending  <= 1'b0;
      rd_pending  <= 1'b0;
      overflow_o  <= 1'b0;
      vram_req_o  <= 1'b0;
      vram_wr_o   <= 1'b0;
      vram_addr_o <= '0;
      vram_data_o <= '0;
      rd_data_o   <= '0;
    end else begin
      state      <= state_n;
      vram_req_o <= state_n != SEQ_IDLE;
      if (write_strobe_i & ~bytesel_i) hi <= bytedata_i;
      wr_incr    <= wr_incr_n;
      rd_incr    <= rd_incr_n;
      wr_addr    <= wr_ack ? wr_addr_n + VRAM_ADDR_W'(wr_incr_n) : wr_addr_n;
      rd_addr    <= rd_ack ? rd_addr_n + VRAM_ADDR_W'(rd_incr_n) : rd_addr_n;
      if (c_data & wr_free) wr_data <= cval;
      wr_pending <= (c_data & wr_free) | (wr_pending & ~wr_ack);
      rd_pending <= ((c_rda | pf) & rd_free) | (rd_pending & ~rd_ack);
      overflow_o <= overflow_o | (c_data & ~wr_free) | (c_rda & ~rd_free);
      // access attributes are frozen when the request launches
      if ((state == SEQ_IDLE) && (state_n != SEQ_IDLE)) begin
        vram_wr_o   <= state_n == SEQ_WR;
        vram_addr_o <= (state_n == SEQ_WR) ? wr_addr : rd_addr;
        vram_data_o <= wr_data;
      end
      if (rd_ack) rd_data_o <= vram_data_i;
    end
  end
endmodule
